// File: rtl/rv32i_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : rv32i_multicycle_sequencer
// Description : Multicycle RV32I phase sequencer; owns memory handshakes,
//               commit strobes, retired-instruction count and sticky fault.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_multicycle_sequencer #(
    parameter int OPCODE_SIZE = 7,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   run,
    input  logic [OPCODE_SIZE-1:0] opcode,
    input  logic                   imem_ready,
    input  logic                   dmem_ready,
    output logic                   imem_req,
    output logic                   ir_write,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic                   pc_write,
    output logic                   rf_write,
    output logic [2:0]             state,
    output logic                   fault,
    output logic [31:0]            instret
);

    localparam logic [OPCODE_SIZE-1:0] c_OP_R      = OPCODE_SIZE'(7'b0110011);
    localparam logic [OPCODE_SIZE-1:0] c_OP_IALU   = OPCODE_SIZE'(7'b0010011);
    localparam logic [OPCODE_SIZE-1:0] c_OP_LOAD   = OPCODE_SIZE'(7'b0000011);
    localparam logic [OPCODE_SIZE-1:0] c_OP_STORE  = OPCODE_SIZE'(7'b0100011);
    localparam logic [OPCODE_SIZE-1:0] c_OP_BRANCH = OPCODE_SIZE'(7'b1100011);
    localparam logic [OPCODE_SIZE-1:0] c_OP_JALR   = OPCODE_SIZE'(7'b1100111);
    localparam logic [OPCODE_SIZE-1:0] c_OP_JAL    = OPCODE_SIZE'(7'b1101111);
    localparam logic [OPCODE_SIZE-1:0] c_OP_LUI    = OPCODE_SIZE'(7'b0110111);
    localparam logic [OPCODE_SIZE-1:0] c_OP_AUIPC  = OPCODE_SIZE'(7'b0010111);

    localparam int                 c_CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6,
        S_RSVD   = 3'd7
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_wait_cnt;
    logic [31:0]        r_instret;

    logic w_is_load;
    logic w_is_store;
    logic w_is_branch;
    logic w_legal;
    logic w_wait_last;

    assign w_is_load   = (opcode == c_OP_LOAD);
    assign w_is_store  = (opcode == c_OP_STORE);
    assign w_is_branch = (opcode == c_OP_BRANCH);
    assign w_legal     = (opcode == c_OP_R)    || (opcode == c_OP_IALU) ||
                         w_is_load || w_is_store || w_is_branch ||
                         (opcode == c_OP_JALR) || (opcode == c_OP_JAL)  ||
                         (opcode == c_OP_LUI)  || (opcode == c_OP_AUIPC);
    assign w_wait_last = (r_wait_cnt == c_CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The counter only survives while a request is held across cycles, so it
    // is zero on every entry into FETCH or MEM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_wait_cnt <= '0;
        end else if ((r_state == S_FETCH) || (r_state == S_MEM)) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instret <= 32'd0;
        end else if (r_state == S_WB) begin
            r_instret <= r_instret + 32'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        imem_req     = 1'b0;
        ir_write     = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        pc_write     = 1'b0;
        rf_write     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (run) w_state_next = S_FETCH;
            end
            S_FETCH: begin
                imem_req = 1'b1;
                // Ready on the last permitted cycle still completes normally.
                if (imem_ready) begin
                    ir_write     = 1'b1;
                    w_state_next = S_DECODE;
                end else if (w_wait_last) begin
                    w_state_next = S_HALT;
                end
            end
            S_DECODE: begin
                w_state_next = w_legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
                w_state_next = (w_is_load || w_is_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = w_is_store;
                if (dmem_ready) begin
                    w_state_next = S_WB;
                end else if (w_wait_last) begin
                    w_state_next = S_HALT;
                end
            end
            S_WB: begin
                pc_write     = 1'b1;
                rf_write     = w_legal && !w_is_store && !w_is_branch;
                w_state_next = run ? S_FETCH : S_IDLE;
            end
            default: begin
                w_state_next = S_HALT;
            end
        endcase
    end

    // HALT is only reachable through a fault, so the flag is a state decode.
    assign fault   = (r_state == S_HALT) || (r_state == S_RSVD);
    assign state   = r_state;
    assign instret = r_instret;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_multicycle_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_rv32i_multicycle_sequencer
// Description : Directed self-checking bench for rv32i_multicycle_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_multicycle_sequencer;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [6:0]  opcode;
    logic        imem_ready;
    logic        dmem_ready;
    logic        imem_req;
    logic        ir_write;
    logic        dmem_req;
    logic        dmem_we;
    logic        pc_write;
    logic        rf_write;
    logic [2:0]  state;
    logic        fault;
    logic [31:0] instret;

    int n_checks = 0;
    int n_pass   = 0;

    rv32i_multicycle_sequencer #(
        .OPCODE_SIZE (7),
        .MEM_TIMEOUT (15)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .run        (run),
        .opcode     (opcode),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .ir_write   (ir_write),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .pc_write   (pc_write),
        .rf_write   (rf_write),
        .state      (state),
        .fault      (fault),
        .instret    (instret)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Advance one edge; inputs change 1 time unit after it, checks 2 after.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    initial begin
        rst_n      = 1'b0;
        run        = 1'b0;
        opcode     = 7'b0110011;
        imem_ready = 1'b1;
        dmem_ready = 1'b1;
        #12;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_instret", instret, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_strobes", {26'd0, imem_req, ir_write, dmem_req, dmem_we, pc_write, rf_write}, 32'd0);

        // R-type, zero wait, run held high.
        tick(); rst_n = 1'b1; run = 1'b1; settle();
        tick(); settle();
        chk("r_fetch_state", {29'd0, state}, 32'd1);
        chk("r_fetch_req_irw", {30'd0, imem_req, ir_write}, 32'd3);
        tick(); settle();
        chk("r_decode_state", {29'd0, state}, 32'd2);
        tick(); settle();
        chk("r_exec_state", {29'd0, state}, 32'd3);
        tick(); settle();
        chk("r_wb_state", {29'd0, state}, 32'd5);
        chk("r_wb_pc_rf", {30'd0, pc_write, rf_write}, 32'd3);
        chk("r_wb_instret_pre", instret, 32'd0);
        tick(); run = 1'b0; settle();
        chk("r_next_fetch", {29'd0, state}, 32'd1);
        chk("r_instret_1", instret, 32'd1);
        tick(); tick(); tick(); tick(); settle();
        chk("r_idle_after", {29'd0, state}, 32'd0);
        chk("r_instret_2", instret, 32'd2);

        // STORE with three data wait cycles.
        opcode = 7'b0100011; dmem_ready = 1'b0; run = 1'b1;
        tick(); settle();
        chk("st_fetch", {29'd0, state}, 32'd1);
        tick(); tick(); run = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (i == 3) dmem_ready = 1'b1;
            settle();
            chk($sformatf("st_mem%0d", i), {28'd0, state, 1'b0}, 32'h8);
            chk($sformatf("st_req_we%0d", i), {30'd0, dmem_req, dmem_we}, 32'd3);
        end
        tick(); settle();
        chk("st_wb_state", {29'd0, state}, 32'd5);
        chk("st_wb_pc_rf", {30'd0, pc_write, rf_write}, 32'd2);
        tick(); settle();
        chk("st_idle", {29'd0, state}, 32'd0);
        chk("st_instret", instret, 32'd3);

        // LOAD, zero wait, run dropped during EXEC.
        opcode = 7'b0000011; run = 1'b1;
        tick(); tick(); tick(); run = 1'b0; settle();
        chk("ld_exec", {29'd0, state}, 32'd3);
        tick(); settle();
        chk("ld_mem_req_we", {29'd0, state == 3'd4, dmem_req, dmem_we}, 32'd6);
        tick(); settle();
        chk("ld_wb_pc_rf", {29'd0, state == 3'd5, pc_write, rf_write}, 32'd7);
        tick(); settle();
        chk("ld_idle", {29'd0, state}, 32'd0);
        chk("ld_instret", instret, 32'd4);

        // Fetch ready arriving on the 15th request cycle completes.
        opcode = 7'b0110011; imem_ready = 1'b0; run = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            if (i == 15) imem_ready = 1'b1;
            settle();
        end
        chk("to15_fetch_irw", {28'd0, state, ir_write}, 32'h3);
        tick(); run = 1'b0; settle();
        chk("to15_decode", {28'd0, state, fault}, 32'h4);
        tick(); tick(); tick(); settle();
        chk("to15_idle_instret", instret, 32'd5);

        // Fetch timeout: 15 wait cycles then HALT.
        imem_ready = 1'b0; run = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick(); settle();
            chk($sformatf("to_fetch%0d", i), {29'd0, state}, 32'd1);
        end
        tick(); settle();
        chk("to_halt", {28'd0, state, fault}, 32'hD);
        chk("to_halt_req", {31'd0, imem_req}, 32'd0);

        // Illegal opcode after a fresh reset.
        rst_n = 1'b0; imem_ready = 1'b1; run = 1'b0; opcode = 7'b1111111;
        settle();
        chk("ill_rst", {28'd0, state, fault}, 32'h0);
        tick(); rst_n = 1'b1; run = 1'b1; settle();
        tick(); tick(); settle();
        chk("ill_decode_pc", {28'd0, state, pc_write}, 32'h4);
        tick(); settle();
        chk("ill_halt", {27'd0, state, fault, pc_write}, 32'h1A);
        for (int i = 0; i < 4; i++) begin
            run = ~run;
            tick(); settle();
        end
        chk("ill_sticky", {28'd0, state, fault}, 32'hD);
        rst_n = 1'b0; settle();
        chk("ill_cleared", {28'd0, state, fault}, 32'h0);

        // Async reset in the middle of a waiting MEM access.
        tick(); rst_n = 1'b1; opcode = 7'b0110011; run = 1'b1; settle();
        tick(); tick(); tick(); tick(); opcode = 7'b0000011; dmem_ready = 1'b0; settle();
        tick(); tick(); tick(); tick(); settle();
        chk("ar_mem", {28'd0, state, dmem_req}, 32'h9);
        chk("ar_instret_pre", instret, 32'd1);
        @(negedge clk);
        rst_n = 1'b0; settle();
        chk("ar_state", {28'd0, state, dmem_req}, 32'h0);
        chk("ar_instret", instret, 32'd0);

        // Retire counter wrap.
        tick(); rst_n = 1'b1; run = 1'b0; opcode = 7'b0110111; dmem_ready = 1'b1; settle();
        force dut.r_instret = 32'hFFFF_FFFF;
        settle();
        release dut.r_instret;
        settle();
        chk("wrap_pre", instret, 32'hFFFF_FFFF);
        run = 1'b1;
        tick(); run = 1'b0; tick(); tick(); tick(); settle();
        chk("wrap_wb_rf", {28'd0, state, rf_write}, 32'hB);
        tick(); settle();
        chk("wrap_post", instret, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rv32i_multicycle_sequencer.md
# rv32i_multicycle_sequencer

Finite-state sequencer that steps the RV32I datapath through fetch, decode, execute, memory and writeback phases, one instruction at a time. It owns the instruction/data memory request handshakes and the commit strobes: IR latch, PC update, register-file write. It sits beside the per-opcode control decoder, which supplies the static datapath mux/ALU controls. It also maintains a retired-instruction counter and a sticky fault flag.

## Interface
Parameters:
- OPCODE_SIZE, 7, opcode width (matches RISCV_PKG)
- MEM_TIMEOUT, 15, max consecutive wait cycles on a memory request before faulting (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- run  in  1  start/continue execution; sampled in IDLE and WB
- opcode  in  OPCODE_SIZE  instruction-register opcode; stable from DECODE through WB
- imem_ready  in  1  instruction memory data valid
- dmem_ready  in  1  data memory access complete
- imem_req  out  1  instruction fetch request
- ir_write  out  1  latch fetched instruction into IR (one-cycle pulse)
- dmem_req  out  1  data memory request
- dmem_we  out  1  data memory write (store)
- pc_write  out  1  commit next PC (one-cycle pulse)
- rf_write  out  1  register-file write enable (one-cycle pulse)
- state  out  3  current state encoding
- fault  out  1  sticky fault: illegal opcode or memory timeout
- instret  out  32  retired instruction count

## Operation
- Legal opcodes: 0110011 R, 0010011 I-ALU, 0000011 LOAD, 0100011 STORE, 1100011 BRANCH, 1100111 JALR, 1101111 JAL, 0110111 LUI, 0010111 AUIPC.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6; 7 unused and treated as HALT.
- IDLE: run=1 -> FETCH; else stay.
- FETCH: imem_req=1. imem_ready=1 -> ir_write=1 in the same cycle, next DECODE. Otherwise stay; on timeout go to HALT.
- DECODE: legal opcode -> EXEC. Illegal opcode -> HALT with fault set.
- EXEC: LOAD/STORE -> MEM; all other legal opcodes -> WB.
- MEM: dmem_req=1; dmem_we=1 only for STORE. dmem_ready=1 -> WB. Otherwise stay; on timeout go to HALT.
- WB:
  - pc_write=1.
  - rf_write=1 for every legal opcode except STORE and BRANCH.
  - instret increments.
  - Next state: run=1 -> FETCH, run=0 -> IDLE.
- HALT: all strobes 0, fault=1. Exits only on reset.
- Timeout: wait counter clears on entry to FETCH/MEM and increments each cycle the request is high with ready low.
  - If ready is low on the MEM_TIMEOUT-th request cycle, next state is HALT and fault=1.
  - Ready high on that cycle is a normal completion.
- run deasserted mid-instruction: the instruction completes through WB, then the sequencer goes to IDLE.
- instret wraps 0xFFFFFFFF -> 0.
- Output timing type:
  - imem_req, dmem_req, dmem_we, pc_write, rf_write, state and fault are Moore decodes of registered state (rf_write and dmem_we also depend on stable opcode).
  - ir_write is Mealy: FETCH & imem_ready.

## Timing
- Reset (async, immediate): state=IDLE; all strobes 0; fault=0; instret=0. A reset during FETCH/MEM drops requests in the same instant.
- First FETCH is one cycle after run is sampled high in IDLE.
- Zero-wait latency:
  - Non-memory instructions take 4 cycles (FETCH, DECODE, EXEC, WB).
  - LOAD/STORE take 5 cycles.
  - Each memory wait cycle adds 1.
- Back-to-back: with run held high, FETCH of the next instruction immediately follows WB; no bubble.
- instret reflects the increment on the cycle after WB.
- Handshake: a request stays high until ready is seen or a timeout occurs. Ready while no request is outstanding is ignored.
- Simultaneous ready and timeout cycle: ready wins.

## Test plan
- Reset, then run=1, R-type 0110011, imem_ready and dmem_ready tied 1:
  - state sequence 1,2,3,5,1.
  - ir_write pulses in cycle 1; pc_write and rf_write pulse in cycle 4; instret=1 after the WB edge.
- STORE 0100011 with dmem_ready delayed 3 cycles:
  - dmem_req=dmem_we=1 for 4 MEM cycles.
  - rf_write=0 in WB; total 8 cycles.
  - LOAD variant: dmem_we=0, rf_write=1.
- Illegal opcode 1111111 in DECODE: next state HALT, fault=1, no pc_write. fault holds under run toggling until rst_n pulses low.
- MEM_TIMEOUT=15, imem_ready held 0:
  - HALT after exactly 15 FETCH cycles.
  - Repeat with ready on the 15th cycle: proceeds to DECODE with fault=0.
- run dropped during EXEC: WB completes (pc_write=1), then IDLE. rst_n asserted mid-MEM clears state, dmem_req and instret asynchronously.
- Preload instret near wrap (force 0xFFFFFFFF): the next retire wraps it to 0.
